mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single data read/write port of mem among the four cores.
//  Replaces the ad-hoc per-core stall priority chains in the top level.
//  Accepts at most one load/store per cycle, registers it toward mem and tracks in-flight reads.
//  Routes each returning read word to the issuing core with a one-cycle valid.
// PARAMETERS
//  NCORE   4   number of requesters; the design is fixed at 4 (pointer is 2 bits)
//  RD_LAT  2   cycles from mem_valid (read) to mem_rdata being valid; legal range 1..7
//  AW      15  word address width (byte address [15:1])
//  DW      16  data width
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         synchronous reset, active-high
//  req_valid  in   4         per-core request; held until granted
//  req_wen    in   4         per-core request: 1=store, 0=load
//  req_addr   in   4*AW      per-core address; core i in [i*AW +: AW]
//  req_wdata  in   4*DW      per-core store data; core i in [i*DW +: DW]
//  grant      out  4         one-hot; request accepted this cycle
//  stall      out  4         req_valid & ~grant
//  mem_ready  in   1         mem can accept a command this cycle
//  mem_valid  out  1         registered command valid
//  mem_wen    out  1         registered store flag
//  mem_addr   out  AW        registered address
//  mem_wdata  out  DW        registered store data
//  mem_rdata  in   DW        read data, valid RD_LAT cycles after a read command
//  rsp_valid  out  4         one-hot; read data for core i is on rsp_data
//  rsp_data   out  DW        returned read word
// BEHAVIOUR
//  - Reset: rr_ptr=0; mem_valid=0, mem_wen=0, mem_addr=0, mem_wdata=0; tag pipe cleared; rsp_valid=0, rsp_data=0.
//  - grant is combinational: if mem_ready=0 or rst=1, grant=0.
//    Otherwise grant the first set req_valid bit scanning rr_ptr, rr_ptr+1, ... (mod 4).
//  - On grant to core i at edge T:
//    - rr_ptr <= i+1 (mod 4). rr_ptr holds when there is no grant.
//    - mem_* registers load core i's payload; mem_valid=1 for cycle T+1 only.
//  - No grant at edge T: mem_valid=0 next cycle. mem_addr/mem_wdata hold their last values.
//  - Read tag pipe: RD_LAT stages of {valid, id[1:0]}. Stage 0 loads {mem_valid & ~mem_wen, id} each cycle.
//    When the last stage is valid: rsp_valid[id]=1 and rsp_data=mem_rdata, registered.
//    This is a one-cycle pulse; rsp_data holds otherwise.
//  - Total load latency, grant to rsp_valid: RD_LAT+2 cycles. Stores produce no response.
//  - Issue throughput: one command per cycle, back-to-back. There is no per-core outstanding limit.
//  - Simultaneous requests from all 4 cores with mem_ready=1 every cycle:
//    grants rotate in strict order starting at rr_ptr. Worst-case wait is 3 cycles.
//  - mem_ready low: all requesters stall. In-flight reads still drain and respond on schedule.
//  - A request that deasserts before being granted is dropped silently. No state is kept for it.
//  - rst mid-operation: flushes the tag pipe. Any later mem_rdata return is ignored (no rsp_valid).
//  - Store and load to the same address in consecutive grants: mem sees them in grant order.
//    The arbiter does no forwarding.
// CONFIGURATION
//  MEM_ARB_WRITE_PRIO_EN defined:
//    - When any store is pending, only stores are eligible for grant. Round-robin applies among stores.
//    - rr_ptr updates as normal on every grant.
//  Undefined: loads and stores are treated alike.
// STRUCTURE
//  - mem_arb_pkg: NCORE, AW, DW, typedef core_id_t [1:0], tag struct {valid, core_id_t}, RD_LAT_MAX=7.
//  - Sub-module rr_pick4: combinational. Inputs 4-bit eligible mask and rr_ptr; outputs one-hot grant and id.
//  - Arbiter top holds rr_ptr, the mem command registers, the tag pipe and the response registers.
// TESTING
//  1. Reset, then core2 load addr 0x0010, mem_ready=1, RD_LAT=2:
//     grant=0100 same cycle; mem_valid 1 cycle later; mem_rdata=0xBEEF returns;
//     rsp_valid=0100 with rsp_data=0xBEEF 4 cycles after grant.
//  2. All 4 req_valid held, rr_ptr=0: grants 0001,0010,0100,1000,0001 on consecutive cycles;
//     stall shows the other three set each cycle.
//  3. mem_ready=0 for 3 cycles with core1 and core3 pending: grant=0, stall=1010.
//     After release: core1 granted, then core3.
//  4. Loads from cores 0,1,2 back-to-back: rsp_valid pulses 0001,0010,0100 on consecutive cycles,
//     each with its own mem_rdata.
//  5. Load granted, then rst asserted 1 cycle later: mem_valid=0 and no rsp_valid after reset;
//     next grant starts at core0.
//  6. MEM_ARB_WRITE_PRIO_EN, core0 load and core3 store pending: core3 granted first, core0 next cycle.
//     Macro undefined: core0 first.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
// Contents: core count, address/data widths, the core id type, the read-tag
// record carried down the tag pipe, and a helper turning a core id into a
// one-hot core mask.
package mem_arb_pkg;

    localparam int NCORE      = 4;
    localparam int AW         = 15;
    localparam int DW         = 16;
    localparam int RD_LAT_MAX = 7;

    typedef logic [1:0] core_id_t;

    // One stage of the read-tag pipe: which core is owed the returning word.
    typedef struct packed {
        logic     valid;
        core_id_t id;
    } tag_t;

    function automatic logic [NCORE-1:0] id_to_onehot(input core_id_t id);
        logic [NCORE-1:0] oh;
        oh = 4'b0001 << id;
        return oh;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick4.sv
// rr_pick4: combinational round-robin picker for four requesters.
// Ports:
//   eligible_i  in  4  requesters allowed to win this cycle
//   rr_ptr_i    in  2  highest-priority requester this cycle
//   grant_o     out 4  one-hot winner (zero when nothing is eligible)
//   id_o        out 2  index of the winner (0 when nothing is eligible)
//   any_o       out 1  a winner exists
module rr_pick4
    import mem_arb_pkg::*;
(
    input  logic [NCORE-1:0] eligible_i,
    input  core_id_t         rr_ptr_i,
    output logic [NCORE-1:0] grant_o,
    output core_id_t         id_o,
    output logic             any_o
);

    // Scan rr_ptr, rr_ptr+1, ... (2-bit wrap) and take the first eligible core.
    always_comb begin
        core_id_t idx;
        grant_o = 4'b0000;
        id_o    = 2'd0;
        any_o   = 1'b0;
        idx     = 2'd0;
        for (int k = 0; k < NCORE; k++) begin
            idx = rr_ptr_i + core_id_t'(k);
            if (!any_o && eligible_i[idx]) begin
                any_o        = 1'b1;
                grant_o[idx] = 1'b1;
                id_o         = idx;
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of mem's single read/write port among
// four cores. One command is accepted per cycle, registered toward mem, and
// each read is tagged so the returning word is routed back to its issuer.
// Optional feature macro: MEM_ARB_WRITE_PRIO_EN (pending stores win over loads).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_wen         per-core request and store flag (4)
//   req_addr/req_wdata        per-core payloads, core i at [i*W +: W]
//   grant, stall              combinational one-hot grant; req_valid & ~grant
//   mem_ready                 mem can take a command this cycle
//   mem_valid/wen/addr/wdata  registered command toward mem
//   mem_rdata                 read word, RD_LAT cycles after a read command
//   rsp_valid, rsp_data       registered one-cycle response to the issuing core
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCORE-1:0]    req_valid,
    input  logic [NCORE-1:0]    req_wen,
    input  logic [NCORE*AW-1:0] req_addr,
    input  logic [NCORE*DW-1:0] req_wdata,
    output logic [NCORE-1:0]    grant,
    output logic [NCORE-1:0]    stall,
    input  logic                mem_ready,
    output logic                mem_valid,
    output logic                mem_wen,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata,
    output logic [NCORE-1:0]    rsp_valid,
    output logic [DW-1:0]       rsp_data
);

    core_id_t               rr_ptr_q, rr_ptr_d;
    logic                   mem_valid_q, mem_valid_d;
    logic                   mem_wen_q, mem_wen_d;
    logic [AW-1:0]          mem_addr_q, mem_addr_d;
    logic [DW-1:0]          mem_wdata_q, mem_wdata_d;
    core_id_t               cmd_id_q, cmd_id_d;
    tag_t [RD_LAT-1:0]      tag_q, tag_d;
    logic [NCORE-1:0]       rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]          rsp_data_q, rsp_data_d;

    logic [NCORE-1:0]       eligible_s;
    logic [NCORE-1:0]       pick_grant_s;
    core_id_t               pick_id_s;
    logic                   pick_any_s;
    logic                   grant_en_s;
    logic                   gnt_any_s;

    // Select which pending requests may compete this cycle.
    always_comb begin
`ifdef MEM_ARB_WRITE_PRIO_EN
        // Any pending store shuts loads out; round-robin then runs among stores.
        if (|(req_valid & req_wen)) begin
            eligible_s = req_valid & req_wen;
        end else begin
            eligible_s = req_valid;
        end
`else
        eligible_s = req_valid;
`endif
    end

    rr_pick4 u_pick (
        .eligible_i (eligible_s),
        .rr_ptr_i   (rr_ptr_q),
        .grant_o    (pick_grant_s),
        .id_o       (pick_id_s),
        .any_o      (pick_any_s)
    );

    // Gate the picker: nothing is granted while mem is busy or in reset.
    always_comb begin
        grant_en_s = mem_ready & ~rst;
        gnt_any_s  = grant_en_s & pick_any_s;
        if (grant_en_s) begin
            grant = pick_grant_s;
        end else begin
            grant = 4'b0000;
        end
        stall = req_valid & ~grant;
    end

    // Next state for the pointer, command registers, tag pipe and response.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        mem_valid_d = gnt_any_s;
        mem_wen_d   = mem_wen_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cmd_id_d    = cmd_id_q;
        if (gnt_any_s) begin
            rr_ptr_d    = pick_id_s + 2'd1;
            mem_wen_d   = req_wen[pick_id_s];
            mem_addr_d  = req_addr[int'(pick_id_s)*AW +: AW];
            mem_wdata_d = req_wdata[int'(pick_id_s)*DW +: DW];
            cmd_id_d    = pick_id_s;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end

        // Only reads enter the pipe as valid; stores never produce a response.
        tag_d    = tag_q;
        tag_d[0] = tag_t'{valid: mem_valid_q & ~mem_wen_q, id: cmd_id_q};
        for (int i = 1; i < RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        // Last stage lines up with mem_rdata; capture it as a one-cycle pulse.
        if (tag_q[RD_LAT-1].valid) begin
            rsp_valid_d = id_to_onehot(tag_q[RD_LAT-1].id);
            rsp_data_d  = mem_rdata;
        end else begin
            rsp_valid_d = 4'b0000;
            rsp_data_d  = rsp_data_q;
        end
    end

    // State registers with synchronous reset; reset also flushes the tag pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= 2'd0;
            mem_valid_q <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= 15'd0;
            mem_wdata_q <= 16'd0;
            cmd_id_q    <= 2'd0;
            tag_q       <= '0;
            rsp_valid_q <= 4'b0000;
            rsp_data_q  <= 16'd0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            mem_valid_q <= mem_valid_d;
            mem_wen_q   <= mem_wen_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cmd_id_q    <= cmd_id_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_wen   = mem_wen_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (RD_LAT=2): a table of per-cycle
// request vectors with hand-computed grant/stall/command values, plus
// hand-written sequences for load latency, back-to-back responses and reset
// flush. A two-stage memory model returns read data keyed by address.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic [NCORE-1:0]    req_valid, req_wen;
    logic [NCORE*AW-1:0] req_addr;
    logic [NCORE*DW-1:0] req_wdata;
    logic [NCORE-1:0]    grant, stall;
    logic                mem_ready;
    logic                mem_valid, mem_wen;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata, mem_rdata;
    logic [NCORE-1:0]    rsp_valid;
    logic [DW-1:0]       rsp_data;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.RD_LAT(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant), .stall(stall),
        .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    // Memory model: read word appears two cycles after the read command.
    logic [AW-1:0] p0_a = 15'd0;
    logic [AW-1:0] p1_a = 15'd0;

    function automatic logic [DW-1:0] rdata_of(input logic [AW-1:0] a);
        if (a == 15'h0010) return 16'hBEEF;
        return {1'b0, a} ^ 16'h5A5A;
    endfunction

    always @(posedge clk) begin
        p0_a <= (mem_valid && !mem_wen) ? mem_addr : 15'h7FFF;
        p1_a <= p0_a;
    end
    assign mem_rdata = rdata_of(p1_a);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_addrs(input logic [AW-1:0] base);
        for (int i = 0; i < NCORE; i++) begin
            req_addr[i*AW +: AW]  = base + AW'(i);
            req_wdata[i*DW +: DW] = 16'hA000 + DW'(i);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic [3:0]    rv;
        logic [3:0]    wen;
        logic          rdy;
        logic [3:0]    g;
        logic [3:0]    st;
        logic          mv;
        logic          mwen;
        logic [AW-1:0] maddr;
    } vec_t;

    vec_t tbl [16];

    initial begin
        // rv, wen, rdy, grant, stall, mem_valid, mem_wen, mem_addr (after edge)
        tbl[0]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 4'b1110, 1'b1, 1'b0, 15'h100};
        tbl[1]  = '{4'b1111, 4'b0000, 1'b1, 4'b0010, 4'b1101, 1'b1, 1'b0, 15'h101};
        tbl[2]  = '{4'b1111, 4'b0000, 1'b1, 4'b0100, 4'b1011, 1'b1, 1'b0, 15'h102};
        tbl[3]  = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 4'b0111, 1'b1, 1'b0, 15'h103};
        tbl[4]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 4'b1110, 1'b1, 1'b0, 15'h100};
        tbl[5]  = '{4'b1010, 4'b0000, 1'b0, 4'b0000, 4'b1010, 1'b0, 1'b0, 15'h000};
        tbl[6]  = '{4'b1010, 4'b0000, 1'b0, 4'b0000, 4'b1010, 1'b0, 1'b0, 15'h000};
        tbl[7]  = '{4'b1010, 4'b0000, 1'b0, 4'b0000, 4'b1010, 1'b0, 1'b0, 15'h000};
        tbl[8]  = '{4'b1010, 4'b0000, 1'b1, 4'b0010, 4'b1000, 1'b1, 1'b0, 15'h101};
        tbl[9]  = '{4'b1000, 4'b0000, 1'b1, 4'b1000, 4'b0000, 1'b1, 1'b0, 15'h103};
        tbl[10] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 15'h000};
        tbl[11] = '{4'b0110, 4'b0000, 1'b1, 4'b0010, 4'b0100, 1'b1, 1'b0, 15'h101};
        tbl[12] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0, 15'h100};
        tbl[13] = '{4'b1001, 4'b1000, 1'b1, 4'b1000, 4'b0001, 1'b1, 1'b1, 15'h103};
`ifdef MEM_ARB_WRITE_PRIO_EN
        tbl[14] = '{4'b1001, 4'b1000, 1'b1, 4'b1000, 4'b0001, 1'b1, 1'b1, 15'h103};
        tbl[15] = '{4'b0001, 4'b1000, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0, 15'h100};
`else
        tbl[14] = '{4'b1001, 4'b1000, 1'b1, 4'b0001, 4'b1000, 1'b1, 1'b0, 15'h100};
        tbl[15] = '{4'b1000, 4'b1000, 1'b1, 4'b1000, 4'b0000, 1'b1, 1'b1, 15'h103};
`endif

        rst = 1'b1;
        req_valid = 4'b0000;
        req_wen = 4'b0000;
        mem_ready = 1'b1;
        req_addr = '0;
        req_wdata = '0;
        set_addrs(15'h100);

        // Reset state: no grant while rst is high, registers cleared.
        @(negedge clk);
        req_valid = 4'b1111;
        #2;
        check("rst_grant", grant, 4'b0000);
        check("rst_stall", stall, 4'b1111);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_mem_valid", mem_valid, 1'b0);
        check("rst_mem_wen", mem_wen, 1'b0);
        check("rst_mem_addr", mem_addr, 15'h0);
        check("rst_mem_wdata", mem_wdata, 16'h0);
        check("rst_rsp_valid", rsp_valid, 4'b0000);
        check("rst_rsp_data", rsp_data, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b0000;

        // Single load from core2: response RD_LAT+2 = 4 cycles after grant.
        req_addr[2*AW +: AW] = 15'h0010;
        @(negedge clk);
        req_valid = 4'b0100;
        #2;
        check("t1_grant", grant, 4'b0100);
        check("t1_stall", stall, 4'b0000);
        @(posedge clk); #1;
        check("t1_mem_valid", mem_valid, 1'b1);
        check("t1_mem_addr", mem_addr, 15'h0010);
        check("t1_mem_wen", mem_wen, 1'b0);
        @(negedge clk);
        req_valid = 4'b0000;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk); #1;
            if (n == 1) check("t1_mem_valid_drop", mem_valid, 1'b0);
            check("t1_rsp_valid", rsp_valid, (n == 3) ? 4'b0100 : 4'b0000);
            if (n >= 3) check("t1_rsp_data", rsp_data, 16'hBEEF);
        end

        // Table-driven grant/stall/command checks, starting from rr_ptr=0.
        do_reset();
        set_addrs(15'h100);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            req_valid = tbl[i].rv;
            req_wen   = tbl[i].wen;
            mem_ready = tbl[i].rdy;
            #2;
            check($sformatf("v%0d_grant", i), grant, tbl[i].g);
            check($sformatf("v%0d_stall", i), stall, tbl[i].st);
            @(posedge clk); #1;
            check($sformatf("v%0d_mem_valid", i), mem_valid, tbl[i].mv);
            if (tbl[i].mv) begin
                check($sformatf("v%0d_mem_wen", i), mem_wen, tbl[i].mwen);
                check($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].maddr);
                if (tbl[i].mwen)
                    check($sformatf("v%0d_mem_wdata", i), mem_wdata, 16'hA003);
            end
        end
        @(negedge clk);
        req_valid = 4'b0000;
        req_wen = 4'b0000;
        mem_ready = 1'b1;

        // Back-to-back loads from cores 0,1,2: responses on consecutive cycles.
        do_reset();
        set_addrs(15'h020);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            req_valid = (n == 0) ? 4'b0111 : (n == 1) ? 4'b0110 : (n == 2) ? 4'b0100 : 4'b0000;
            #2;
            check($sformatf("b2b_grant%0d", n), grant, (n < 3) ? (4'b0001 << n) : 4'b0000);
            @(posedge clk); #1;
            if (n >= 3 && n <= 5) begin
                check($sformatf("b2b_rsp_valid%0d", n), rsp_valid, 4'b0001 << (n - 3));
                check($sformatf("b2b_rsp_data%0d", n), rsp_data, rdata_of(15'h020 + 15'(n - 3)));
            end else begin
                check($sformatf("b2b_rsp_valid%0d", n), rsp_valid, 4'b0000);
            end
        end

        // Reset one cycle after a load grant: pipe flushed, pointer back to 0.
        do_reset();
        set_addrs(15'h100);
        @(negedge clk);
        req_valid = 4'b0010;
        #2;
        check("rf_grant", grant, 4'b0010);
        @(posedge clk); #1;
        check("rf_mem_valid", mem_valid, 1'b1);
        @(negedge clk);
        req_valid = 4'b0000;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rf_mem_valid_cleared", mem_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            check($sformatf("rf_rsp_valid%0d", n), rsp_valid, 4'b0000);
        end
        @(negedge clk);
        req_valid = 4'b1111;
        #2;
        check("rf_next_grant", grant, 4'b0001);
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
